// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : text_pkg
//  Purpose  : Shared constants for the serial terminal text writer: default
//             screen geometry, the blank fill character, control codes,
//             the writer state encoding and the received-byte classifier.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package text_pkg;

  // Default screen geometry and fill character
  localparam int          COLS  = 40;
  localparam int          ROWS  = 30;
  localparam logic [7:0]  BLANK = 8'h20;

  // Control codes acted upon by the writer
  localparam logic [7:0]  CC_BS  = 8'h08;
  localparam logic [7:0]  CC_TAB = 8'h09;
  localparam logic [7:0]  CC_LF  = 8'h0A;
  localparam logic [7:0]  CC_FF  = 8'h0C;
  localparam logic [7:0]  CC_CR  = 8'h0D;

  // Writer states
  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_CLR_SCR  = 2'd1;
  localparam logic [1:0]  ST_CLR_LINE = 2'd2;

  typedef enum logic [2:0] {
    CLS_IGNORE,
    CLS_PRINT,
    CLS_CR,
    CLS_LF,
    CLS_BS,
    CLS_TAB,
    CLS_FF
  } byte_class_e;

  // Maps a received byte onto the action the writer takes for it.
  function automatic byte_class_e classify_byte(input logic [7:0] b);
    byte_class_e cls;
    cls = CLS_IGNORE;
    if (b >= 8'h20 && b <= 8'h7E) begin
      cls = CLS_PRINT;
    end else begin
      case (b)
        CC_CR:   cls = CLS_CR;
        CC_LF:   cls = CLS_LF;
        CC_BS:   cls = CLS_BS;
        CC_TAB:  cls = CLS_TAB;
        CC_FF:   cls = CLS_FF;
        default: cls = CLS_IGNORE;
      endcase
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_writer.sv
`default_nettype none
// ============================================================================
//  Module   : text_writer
//  Purpose  : Consumes bytes from the UART receiver, writes printable chars
//             into text RAM, interprets control codes, and scrolls by
//             rotating the RAM row shown at screen row 0.
//  Ports    : i_clk/i_rstn      pixel clock, async active-low reset
//             i_rx_data/valid   received byte handshake, o_rx_ready accepts
//             o_we/o_waddr/o_wdata  text RAM write port {ram_row, col}
//             o_wr_cell_x/y     write cursor in screen coordinates
//             o_top_row         RAM row displayed at screen row 0
//  Revision : 1.0  initial release
// ============================================================================
module text_writer #(
  parameter int         COLS  = text_pkg::COLS,
  parameter int         ROWS  = text_pkg::ROWS,
  parameter logic [7:0] BLANK = text_pkg::BLANK
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_we,
  output logic [10:0] o_waddr,
  output logic [7:0]  o_wdata,
  output logic [5:0]  o_wr_cell_x,
  output logic [4:0]  o_wr_cell_y,
  output logic [4:0]  o_top_row
);

  import text_pkg::*;

  localparam logic [5:0] c_COLS_M1 = 6'(COLS - 1);
  localparam logic [4:0] c_ROWS_M1 = 5'(ROWS - 1);
  localparam logic [5:0] c_ROWS    = 6'(ROWS);

  logic [1:0]  state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [4:0]  top_q, top_d;
  logic        we_q, we_d;
  logic [10:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [4:0]  crow_q, crow_d;    // clear pointer: RAM row
  logic [5:0]  ccol_q, ccol_d;    // clear pointer: column

  byte_class_e w_cls;
  logic [5:0]  w_row_sum;
  logic [4:0]  w_cur_row;
  logic [4:0]  w_top_inc;
  logic [6:0]  w_tab_raw;
  logic [5:0]  w_tab_x;
  logic        w_nl;

  assign w_cls = classify_byte(i_rx_data);

  // RAM row of the cursor: (y + top) mod ROWS, both operands < ROWS so one
  // conditional subtract is enough.
  assign w_row_sum = {1'b0, y_q} + {1'b0, top_q};
  assign w_cur_row = (w_row_sum >= c_ROWS) ? 5'(w_row_sum - c_ROWS) : w_row_sum[4:0];
  assign w_top_inc = (top_q == c_ROWS_M1) ? 5'd0 : top_q + 5'd1;

  // Next tab stop computed one bit wider so x=56..63 cannot wrap to 0.
  assign w_tab_raw = {1'b0, x_q[5:3], 3'b000} + 7'd8;
  assign w_tab_x   = (w_tab_raw > {1'b0, c_COLS_M1}) ? c_COLS_M1 : w_tab_raw[5:0];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    top_d   = top_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    crow_d  = crow_q;
    ccol_d  = ccol_q;
    w_nl    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (w_cls)
            CLS_PRINT: begin
              we_d    = 1'b1;
              waddr_d = {w_cur_row, x_q};
              wdata_d = i_rx_data;
              if (x_q == c_COLS_M1) begin
                x_d  = 6'd0;
                w_nl = 1'b1;
              end else begin
                x_d = x_q + 6'd1;
              end
            end
            CLS_CR:  x_d  = 6'd0;
            CLS_LF:  w_nl = 1'b1;
            CLS_BS:  if (x_q != 6'd0) x_d = x_q - 6'd1;
            CLS_TAB: x_d  = w_tab_x;
            CLS_FF: begin
              x_d     = 6'd0;
              y_d     = 5'd0;
              top_d   = 5'd0;
              crow_d  = 5'd0;
              ccol_d  = 6'd0;
              state_d = ST_CLR_SCR;
            end
            default: ;
          endcase

          // At the bottom line the screen scrolls: the old top RAM row
          // becomes the new bottom line and is blanked.
          if (w_nl) begin
            if (y_q != c_ROWS_M1) begin
              y_d = y_q + 5'd1;
            end else begin
              top_d   = w_top_inc;
              crow_d  = top_q;
              ccol_d  = 6'd0;
              state_d = ST_CLR_LINE;
            end
          end
        end
      end

      ST_CLR_SCR: begin
        we_d    = 1'b1;
        waddr_d = {crow_q, ccol_q};
        wdata_d = BLANK;
        if (ccol_q == c_COLS_M1) begin
          ccol_d = 6'd0;
          if (crow_q == c_ROWS_M1) begin
            crow_d  = 5'd0;
            state_d = ST_IDLE;
          end else begin
            crow_d = crow_q + 5'd1;
          end
        end else begin
          ccol_d = ccol_q + 6'd1;
        end
      end

      ST_CLR_LINE: begin
        we_d    = 1'b1;
        waddr_d = {crow_q, ccol_q};
        wdata_d = BLANK;
        if (ccol_q == c_COLS_M1) begin
          ccol_d  = 6'd0;
          state_d = ST_IDLE;
        end else begin
          ccol_d = ccol_q + 6'd1;
        end
      end

      default: state_d = ST_CLR_SCR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_CLR_SCR;
      x_q     <= 6'd0;
      y_q     <= 5'd0;
      top_q   <= 5'd0;
      we_q    <= 1'b0;
      waddr_q <= 11'd0;
      wdata_q <= BLANK;
      crow_q  <= 5'd0;
      ccol_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      top_q   <= top_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      crow_q  <= crow_d;
      ccol_q  <= ccol_d;
    end
  end

  assign o_rx_ready  = (state_q == ST_IDLE);
  assign o_we        = we_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_wr_cell_x = x_q;
  assign o_wr_cell_y = y_q;
  assign o_top_row   = top_q;

endmodule
`default_nettype wire

// File: tb/tb_text_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_text_writer
//  Purpose  : Self-checking bench for text_writer. A terminal-level model
//             predicts every RAM write and the cursor/scroll state.
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_writer;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic        o_we;
  logic [10:0] o_waddr;
  logic [7:0]  o_wdata;
  logic [5:0]  o_wr_cell_x;
  logic [4:0]  o_wr_cell_y;
  logic [4:0]  o_top_row;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_wr_cell_x (o_wr_cell_x),
    .o_wr_cell_y (o_wr_cell_y),
    .o_top_row   (o_top_row)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model state: cursor, scroll offset, and expected writes {addr, data}
  int          mx = 0, my = 0, mtop = 0;
  logic [18:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ramrow(input int y);
    return (y + mtop) % ROWS;
  endfunction

  task automatic push_clear_row(input int r);
    for (int c = 0; c < COLS; c++) exp_q.push_back({5'(r), 6'(c), 8'h20});
  endtask

  task automatic push_clear_screen();
    for (int r = 0; r < ROWS; r++) push_clear_row(r);
  endtask

  task automatic model_newline();
    if (my < ROWS - 1) begin
      my++;
    end else begin
      push_clear_row(mtop);
      mtop = (mtop + 1) % ROWS;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({5'(ramrow(my)), 6'(mx), b});
      if (mx == COLS - 1) begin
        mx = 0;
        model_newline();
      end else begin
        mx++;
      end
    end else begin
      case (b)
        8'h0D: mx = 0;
        8'h0A: model_newline();
        8'h08: if (mx > 0) mx--;
        8'h09: begin
          mx = (mx / 8 + 1) * 8;
          if (mx > COLS - 1) mx = COLS - 1;
        end
        8'h0C: begin
          mx = 0; my = 0; mtop = 0;
          push_clear_screen();
        end
        default: ;
      endcase
    end
  endtask

  // Write monitor: every strobe must match the oldest predicted write.
  always @(negedge i_clk) begin
    if (i_rstn && o_we) begin
      if (exp_q.size() == 0) begin
        check("wr_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        check("wr", {13'd0, o_waddr, o_wdata}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  // with i_rx_valid still high so bytes can go back-to-back.
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && guard < 3000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_rx_ready) begin
      check("send_timeout", 32'(guard), 32'd0);
    end else begin
      model_byte(b);
    end
    @(negedge i_clk);
  endtask

  task automatic send1(input logic [7:0] b);
    send(b);
    i_rx_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    i_rx_valid = 1'b0;
    while (!(exp_q.size() == 0 && o_rx_ready) && guard < 5000) begin
      @(negedge i_clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"},   32'(o_wr_cell_x), 32'(mx));
    check({tag, "_y"},   32'(o_wr_cell_y), 32'(my));
    check({tag, "_top"}, 32'(o_top_row),   32'(mtop));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    32'(o_we),        32'd0);
    check({tag, "_waddr"}, 32'(o_waddr),     32'd0);
    check({tag, "_wdata"}, 32'(o_wdata),     32'h20);
    check({tag, "_x"},     32'(o_wr_cell_x), 32'd0);
    check({tag, "_y"},     32'(o_wr_cell_y), 32'd0);
    check({tag, "_top"},   32'(o_top_row),   32'd0);
    check({tag, "_rdy"},   32'(o_rx_ready),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    logic [7:0] b;

    // Reset state and power-on clear
    repeat (3) @(negedge i_clk);
    check_reset_values("rst");
    i_rstn = 1'b1;
    push_clear_screen();
    drain();
    check("init_rdy", 32'(o_rx_ready), 32'd1);
    check_cursor("init");

    // Back-to-back printable bytes, ready stays high
    send("A");
    check("ab_rdy", 32'(o_rx_ready), 32'd1);
    send("B");
    check("ab_rdy2", 32'(o_rx_ready), 32'd1);
    i_rx_valid = 1'b0;
    drain();
    check_cursor("ab");

    // Move to (39,5): CR, 5 LF, tabs capped at the last column
    send1(8'h0D);
    for (int i = 0; i < 5; i++) send1(8'h0A);
    for (int i = 0; i < 5; i++) send1(8'h09);
    drain();
    check_cursor("at39_5");
    send1("Z");
    drain();
    check_cursor("wrap");
    send1(8'h08);
    drain();
    check_cursor("bs0");
    send1("a"); send1("b"); send1("c");
    send1(8'h09);
    drain();
    check_cursor("tab3");
    for (int i = 0; i < 4; i++) send1(8'h09);
    send1(8'h08);
    drain();
    check_cursor("at38");
    send1(8'h09);
    drain();
    check_cursor("tab38");

    // Scroll at the bottom line from (7,29)
    while (my < ROWS - 1) send1(8'h0A);
    send1(8'h0D);
    for (int i = 0; i < 7; i++) send1(" ");
    drain();
    check_cursor("at7_29");
    send1(8'h0A);
    cnt = 0;
    while (!o_rx_ready && cnt < 100) begin
      cnt++;
      @(negedge i_clk);
    end
    check("lf_rdy_low", 32'(cnt), 32'd40);
    drain();
    check_cursor("scroll1");
    for (int i = 0; i < ROWS - 1; i++) send1(8'h0A);
    drain();
    check_cursor("scroll_wrap");
    check("top_wrapped", 32'(o_top_row), 32'd0);

    // Form feed with top=12, next byte held during the clear
    for (int i = 0; i < 12; i++) send1(8'h0A);
    drain();
    check("top12", 32'(o_top_row), 32'd12);
    send(8'h0C);
    check_cursor("ff_imm");
    send("Q");
    i_rx_valid = 1'b0;
    drain();
    check_cursor("ff_q");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = 8'($urandom_range(32, 126));
      else if (r < 62) b = 8'h0D;
      else if (r < 74) b = 8'h0A;
      else if (r < 80) b = 8'h08;
      else if (r < 87) b = 8'h09;
      else if (r < 88) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      send(b);
      if ($urandom_range(0, 3) == 0) begin
        i_rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge i_clk);
      end
      if (n % 50 == 49) begin
        drain();
        check_cursor("rand");
      end
    end
    drain();
    check_cursor("rand_end");

    // Reset in the middle of a line clear
    while (my < ROWS - 1) send1(8'h0A);
    drain();
    send1(8'h0A);
    repeat (10) @(negedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    mx = 0; my = 0; mtop = 0;
    repeat (3) @(negedge i_clk);
    check_reset_values("midrst_hold");
    i_rstn = 1'b1;
    push_clear_screen();
    drain();
    check_cursor("post_rst");
    send1("K");
    drain();
    check_cursor("post_rst_k");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
